// File: rtl/fb_arbiter.sv
// fb_arbiter: schedules the framebuffer RAM between 3x-scaled VGA scanout and Game Boy pixel writes; define FB_ARB_STATS_EN to add stall_count
module fb_arbiter #(
  parameter int X_OFF = 80,
  parameter int Y_OFF = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  vga_x,
  input  logic [9:0]  vga_y,
  input  logic        vga_pixel_active,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_x,
  input  logic [7:0]  wr_y,
  input  logic [1:0]  wr_data,
  output logic        wr_oob,
  output logic [14:0] fb_addr,
  output logic        fb_we,
  output logic [1:0]  fb_wdata,
  input  logic [1:0]  fb_rdata,
  output logic [1:0]  pix_index,
  output logic        pix_in_window
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0] stall_count
`endif
);
  localparam logic [9:0] X_LO = 10'(X_OFF);
  localparam logic [9:0] X_HI = 10'(X_OFF + 480);
  localparam logic [9:0] Y_LO = 10'(Y_OFF);
  localparam logic [9:0] Y_HI = 10'(Y_OFF + 432);
  logic [1:0] sx, sy, sx_c;
  logic [7:0] gx, gy, gx_c;
  logic synced, in_win, read_slot, in_range, win_d1, slot_d1;
  function automatic logic [14:0] lin(input logic [7:0] y, input logic [7:0] x);
    return ({7'd0, y} << 7) + ({7'd0, y} << 5) + {7'd0, x};
  endfunction
  always_comb begin
    in_win = vga_pixel_active && vga_x >= X_LO && vga_x < X_HI && vga_y >= Y_LO && vga_y < Y_HI;
    sx_c = vga_x == X_LO ? 2'd0 : sx;
    gx_c = vga_x == X_LO ? 8'd0 : gx;
    read_slot = synced && in_win && sx_c == 2'd0;
    in_range = wr_x < 8'd160 && wr_y < 8'd144;
    wr_ready = reset || !read_slot;
    fb_addr = reset ? 15'd0 : read_slot ? lin(gy, gx_c) : lin(wr_y, wr_x);
    fb_we = !reset && !read_slot && wr_valid && in_range;
    fb_wdata = reset ? 2'd0 : wr_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {sx, gx, sy, gy} <= '0;
      {synced, wr_oob, win_d1, slot_d1, pix_in_window} <= '0;
      pix_index <= 2'd0;
    end else begin
      if (vga_y == 10'd0) synced <= 1'b1;
      if (wr_valid && wr_ready && !in_range) wr_oob <= 1'b1;
      if (in_win) begin
        sx <= sx_c == 2'd2 ? 2'd0 : sx_c + 2'd1;
        gx <= sx_c == 2'd2 ? gx_c + 8'd1 : gx_c;
      end
      if (vga_x == 10'd0) begin
        sy <= (vga_y == Y_LO || sy == 2'd2) ? 2'd0 : sy + 2'd1;
        gy <= vga_y == Y_LO ? 8'd0 : (sy == 2'd2 && gy != 8'd143) ? gy + 8'd1 : gy;
      end
      win_d1 <= synced && in_win;
      slot_d1 <= read_slot;
      pix_in_window <= win_d1;
      pix_index <= !win_d1 ? 2'd0 : slot_d1 ? fb_rdata : pix_index;
    end
  end
`ifdef FB_ARB_STATS_EN
  always_ff @(posedge clk)
    stall_count <= (reset || (vga_y == 10'd0 && vga_x == 10'd0)) ? 16'd0 :
                   (wr_valid && !wr_ready && stall_count != 16'hffff) ? stall_count + 16'd1 : stall_count;
`endif
endmodule
